// File: rtl/snake_body_tracker_if.sv
// ---------------------------------------------------------------------------
// snake_body_tracker_if
// Groups the step/read/status signals of the snake body tracker.
//   master : game/drawing side, drives step, dir, grow, rd_idx
//   slave  : tracker side, drives the read port, length/full, vacated cell,
//            busy/done and the collision flags
// clk and reset are not part of this bundle.
// ---------------------------------------------------------------------------
interface snake_body_tracker_if #(
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int MAX_LEN = 16
);
  localparam int IDXW = $clog2(MAX_LEN);
  localparam int LENW = $clog2(MAX_LEN + 1);

  logic            step;
  logic [1:0]      dir;
  logic            grow;
  logic [IDXW-1:0] rd_idx;
  logic [XW-1:0]   rd_x;
  logic [YW-1:0]   rd_y;
  logic            rd_valid;
  logic [LENW-1:0] length;
  logic            full;
  logic [XW-1:0]   vac_x;
  logic [YW-1:0]   vac_y;
  logic            vac_valid;
  logic            busy;
  logic            done;
  logic            collide;
  logic            wall;
  logic            dead;

  modport master (
    output step, dir, grow, rd_idx,
    input  rd_x, rd_y, rd_valid, length, full, vac_x, vac_y, vac_valid,
           busy, done, collide, wall, dead
  );

  modport slave (
    input  step, dir, grow, rd_idx,
    output rd_x, rd_y, rd_valid, length, full, vac_x, vac_y, vac_valid,
           busy, done, collide, wall, dead
  );
endinterface

// File: rtl/snake_body_tracker.sv
// ---------------------------------------------------------------------------
// snake_body_tracker
// Stores up to MAX_LEN snake segment coordinates (seg 0 = head) and moves the
// snake one SEG step per accepted step request. Reversal requests are ignored,
// grow lengthens the snake, and after each move a sequential scan compares the
// new head against every body segment to detect self collision.
//
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : snake_body_tracker_if.slave
//            step/dir/grow  move request (accepted when not busy and not dead)
//            rd_idx -> rd_x/rd_y/rd_valid  combinational segment read port
//            length/full    current length, length == MAX_LEN
//            vac_x/vac_y/vac_valid  cell vacated by the last move
//            busy/done      move in progress, one-cycle end-of-move pulse
//            collide/wall/dead  sticky collision flags
//
// Build option:
//   SNAKE_WRAP_EN  when defined the head wraps at the screen edges and wall
//                  hits never occur; otherwise hitting an edge ends the game.
// ---------------------------------------------------------------------------
module snake_body_tracker #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int SEG      = 10,
  parameter int XSCREEN  = 160,
  parameter int YSCREEN  = 120,
  parameter int X0       = 80,
  parameter int Y0       = 30
) (
  input logic                 clk,
  input logic                 reset,
  snake_body_tracker_if.slave bus
);

  localparam int IDXW = $clog2(MAX_LEN);
  localparam int LENW = $clog2(MAX_LEN + 1);

  localparam logic [XW-1:0]   SEG_X    = XW'(SEG);
  localparam logic [YW-1:0]   SEG_Y    = YW'(SEG);
  localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);
  localparam logic [LENW-1:0] LEN_MAX  = LENW'(MAX_LEN);
  localparam logic [LENW-1:0] LEN_INIT = LENW'(INIT_LEN);
`ifdef SNAKE_WRAP_EN
  localparam logic [XW-1:0]   X_LAST   = XW'(XSCREEN - SEG);
  localparam logic [YW-1:0]   Y_LAST   = YW'(YSCREEN - SEG);
`else
  localparam logic [XW-1:0]   X_RIGHT_LIM = XW'(XSCREEN - 2 * SEG);
  localparam logic [YW-1:0]   Y_DOWN_LIM  = YW'(YSCREEN - 2 * SEG);
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE, DEAD} state_t;
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  logic [XW-1:0]   seg_x [MAX_LEN];
  logic [YW-1:0]   seg_y [MAX_LEN];
  state_t          state;
  dir_t            cur_dir;
  dir_t            eff_dir;
  logic [LENW-1:0] len_q;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] tail_idx;
  logic [XW-1:0]   vac_x_q;
  logic [YW-1:0]   vac_y_q;
  logic            vac_valid_q;
  logic            busy_q;
  logic            done_q;
  logic            collide_q;
  logic            wall_q;
  logic            scan_hit;
  logic [XW-1:0]   new_x;
  logic [YW-1:0]   new_y;
  logic            wall_hit;
  logic            seg_match;
  logic            is_full;

  assign tail_idx  = IDXW'(len_q - LEN_ONE);
  assign is_full   = (len_q == LEN_MAX);
  assign seg_match = (seg_x[0] == seg_x[idx]) && (seg_y[0] == seg_y[idx]);

  // Direction filter and next head position. Opposite directions are bitwise
  // complements of each other in the dir encoding, so a reversal is simply
  // dir == ~cur_dir.
  always_comb begin
    eff_dir  = (bus.dir == ~cur_dir) ? cur_dir : dir_t'(bus.dir);
    new_x    = seg_x[0];
    new_y    = seg_y[0];
    wall_hit = 1'b0;
    case (eff_dir)
      DIR_RIGHT: begin
`ifdef SNAKE_WRAP_EN
        new_x = (seg_x[0] >= X_LAST) ? '0 : seg_x[0] + SEG_X;
`else
        wall_hit = (seg_x[0] > X_RIGHT_LIM);
        new_x    = seg_x[0] + SEG_X;
`endif
      end
      DIR_LEFT: begin
`ifdef SNAKE_WRAP_EN
        new_x = (seg_x[0] < SEG_X) ? X_LAST : seg_x[0] - SEG_X;
`else
        wall_hit = (seg_x[0] < SEG_X);
        new_x    = seg_x[0] - SEG_X;
`endif
      end
      DIR_DOWN: begin
`ifdef SNAKE_WRAP_EN
        new_y = (seg_y[0] >= Y_LAST) ? '0 : seg_y[0] + SEG_Y;
`else
        wall_hit = (seg_y[0] > Y_DOWN_LIM);
        new_y    = seg_y[0] + SEG_Y;
`endif
      end
      DIR_UP: begin
`ifdef SNAKE_WRAP_EN
        new_y = (seg_y[0] < SEG_Y) ? Y_LAST : seg_y[0] - SEG_Y;
`else
        wall_hit = (seg_y[0] < SEG_Y);
        new_y    = seg_y[0] - SEG_Y;
`endif
      end
      default: ;
    endcase
  end

  // Move engine. A move shifts the whole body array in one edge; the collision
  // scan then walks idx 1..length-1 one compare per cycle. Matches collect in
  // scan_hit so collide only becomes visible together with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? XW'(X0 - i * SEG) : '0;
        seg_y[i] <= (i < INIT_LEN) ? YW'(Y0) : '0;
      end
      state       <= IDLE;
      cur_dir     <= DIR_RIGHT;
      len_q       <= LEN_INIT;
      idx         <= '0;
      vac_x_q     <= '0;
      vac_y_q     <= '0;
      vac_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      collide_q   <= 1'b0;
      wall_q      <= 1'b0;
      scan_hit    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.step) begin
            cur_dir <= eff_dir;
            busy_q  <= 1'b1;
            if (wall_hit) begin
              wall_q <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              seg_x[0] <= new_x;
              seg_y[0] <= new_y;
              // Growing keeps the old tail in place, so nothing is vacated.
              if (bus.grow && !is_full) begin
                len_q       <= len_q + LEN_ONE;
                vac_valid_q <= 1'b0;
              end else begin
                vac_x_q     <= seg_x[tail_idx];
                vac_y_q     <= seg_y[tail_idx];
                vac_valid_q <= 1'b1;
              end
              idx      <= IDXW'(1);
              scan_hit <= 1'b0;
              state    <= SCAN;
            end
          end
        end
        SCAN: begin
          if (seg_match) scan_hit <= 1'b1;
          if (idx == tail_idx) begin
            collide_q <= collide_q | scan_hit | seg_match;
            done_q    <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= (collide_q || wall_q) ? DEAD : IDLE;
        end
        DEAD: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_x      = (int'(bus.rd_idx) < MAX_LEN) ? seg_x[bus.rd_idx] : '0;
  assign bus.rd_y      = (int'(bus.rd_idx) < MAX_LEN) ? seg_y[bus.rd_idx] : '0;
  assign bus.rd_valid  = (LENW'(bus.rd_idx) < len_q);
  assign bus.length    = len_q;
  assign bus.full      = is_full;
  assign bus.vac_x     = vac_x_q;
  assign bus.vac_y     = vac_y_q;
  assign bus.vac_valid = vac_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.collide   = collide_q;
  assign bus.wall      = wall_q;
  assign bus.dead      = collide_q | wall_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// ---------------------------------------------------------------------------
// tb_snake_body_tracker
// Self-checking bench for snake_body_tracker. Two instances share clock and
// reset: dut (MAX_LEN=16) and dut5 (MAX_LEN=5, for the full/grow case).
// A small reference model of the snake pushes the expected result of each
// step into a queue; the entry is popped when the DUT raises done.
// Honours SNAKE_WRAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_snake_body_tracker;

  localparam int SEG = 10;
  localparam int XS  = 160;
  localparam int YS  = 120;

  typedef struct {
    int hx, hy, tx, ty, len, vx, vy;
    bit vv, col, wal;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  // reference model state
  int mx [16];
  int my [16];
  int mlen, mdir, mvx, mvy;
  bit mvv, mcol, mwall;

  always #5 clk = ~clk;

  snake_body_tracker_if #(.XW(8), .YW(7), .MAX_LEN(16)) bus ();
  snake_body_tracker_if #(.XW(8), .YW(7), .MAX_LEN(5))  bus5 ();

  snake_body_tracker #(.MAX_LEN(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  snake_body_tracker #(.MAX_LEN(5))  dut5 (.clk(clk), .reset(reset), .bus(bus5));

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mx[i] = (i < 4) ? 80 - 10 * i : 0;
      my[i] = (i < 4) ? 30 : 0;
    end
    mlen = 4; mdir = 0; mvx = 0; mvy = 0; mvv = 0; mcol = 0; mwall = 0;
  endfunction

  // Model one accepted step and queue the expected outcome.
  function automatic void model_step(input int d, input bit g, input int maxl);
    exp_t e;
    int   ed, nx, ny;
    bit   hitw;
    ed   = (d == 3 - mdir) ? mdir : d;
    mdir = ed;
    nx   = mx[0];
    ny   = my[0];
    hitw = 0;
    case (ed)
`ifdef SNAKE_WRAP_EN
      0: nx = (mx[0] == XS - SEG) ? 0 : mx[0] + SEG;
      3: nx = (mx[0] == 0) ? XS - SEG : mx[0] - SEG;
      1: ny = (my[0] == YS - SEG) ? 0 : my[0] + SEG;
      default: ny = (my[0] == 0) ? YS - SEG : my[0] - SEG;
`else
      0: begin hitw = mx[0] > XS - 2 * SEG; nx = mx[0] + SEG; end
      3: begin hitw = mx[0] < SEG;          nx = mx[0] - SEG; end
      1: begin hitw = my[0] > YS - 2 * SEG; ny = my[0] + SEG; end
      default: begin hitw = my[0] < SEG;    ny = my[0] - SEG; end
`endif
    endcase
    if (hitw) begin
      mwall = 1;
      e.lat = 0;
    end else begin
      if (g && mlen < maxl) begin
        for (int i = mlen; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
        mlen++;
        mvv = 0;
      end else begin
        mvx = mx[mlen-1]; mvy = my[mlen-1]; mvv = 1;
        for (int i = mlen - 1; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
      end
      mx[0] = nx; my[0] = ny;
      for (int i = 1; i < mlen; i++) if (mx[i] == nx && my[i] == ny) mcol = 1;
      e.lat = mlen - 1;
    end
    e.hx = mx[0]; e.hy = my[0]; e.tx = mx[mlen-1]; e.ty = my[mlen-1];
    e.len = mlen; e.vx = mvx; e.vy = mvy; e.vv = mvv; e.col = mcol; e.wal = mwall;
    sb.push_back(e);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.step = 1'b0;  bus.grow = 1'b0;  bus.dir = 2'b00;
    bus5.step = 1'b0; bus5.grow = 1'b0; bus5.dir = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Pulse step for one edge, optionally poke another step while busy, then
  // wait (bounded) for done. Returns on the negedge where done is high.
  task automatic drive_step(input bit sel, input logic [1:0] d, input bit g,
                            input bit poke, input int budget,
                            output int cycles, output bit seen);
    @(negedge clk);
    if (sel) begin bus5.step = 1'b1; bus5.dir = d; bus5.grow = g; end
    else     begin bus.step  = 1'b1; bus.dir  = d; bus.grow  = g; end
    @(negedge clk);
    bus5.step = 1'b0; bus5.grow = 1'b0;
    bus.step  = 1'b0; bus.grow  = 1'b0;
    if (poke) begin bus.step = 1'b1; bus.dir = 2'b01; end
    cycles = 0;
    seen   = sel ? bus5.done : bus.done;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      bus.step = 1'b0;
      cycles++;
      seen = sel ? bus5.done : bus.done;
    end
    bus.step = 1'b0;
  endtask

  task automatic read_seg(input bit sel, input int i, output logic [7:0] x,
                          output logic [6:0] y, output logic v);
    @(negedge clk);
    if (sel) begin
      bus5.rd_idx = 3'(i); #1;
      x = bus5.rd_x; y = bus5.rd_y; v = bus5.rd_valid;
    end else begin
      bus.rd_idx = 4'(i); #1;
      x = bus.rd_x; y = bus.rd_y; v = bus.rd_valid;
    end
  endtask

  task automatic test_reset();
    logic [7:0] x; logic [6:0] y; logic v;
    do_reset();
    compared++; if (bus.length !== 5'd4) begin mismatched++; $display("[TB] FAIL reset_length: got %0d expected 4", bus.length); end
    compared++; if ({bus.busy, bus.dead, bus.done, bus.vac_valid, bus.full} !== 5'b0) begin mismatched++; $display("[TB] FAIL reset_flags: got busy/dead/done/vac_valid/full=%b expected 00000", {bus.busy, bus.dead, bus.done, bus.vac_valid, bus.full}); end
    for (int i = 0; i < 5; i++) begin
      read_seg(0, i, x, y, v);
      compared++;
      if (i < 4 && (x !== 8'(80 - 10 * i) || y !== 7'd30 || v !== 1'b1)) begin
        mismatched++; $display("[TB] FAIL reset_seg%0d: got (%0d,%0d,v=%b) expected (%0d,30,v=1)", i, x, y, v, 80 - 10 * i);
      end else if (i == 4 && v !== 1'b0) begin
        mismatched++; $display("[TB] FAIL reset_seg4_valid: got %b expected 0", v);
      end
    end
  endtask

  task automatic test_move_right();
    exp_t e; int cyc; bit seen; logic [7:0] x; logic [6:0] y; logic v;
    do_reset();
    model_step(0, 0, 16);
    drive_step(0, 2'b00, 1'b0, 1'b0, 20, cyc, seen);
    e = sb.pop_front();
    compared++; if (!seen || cyc != e.lat) begin mismatched++; $display("[TB] FAIL right_latency: got %0d (seen=%0b) expected %0d", cyc, seen, e.lat); end
    compared++; if (bus.collide !== e.col || bus.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL right_flags: got collide=%b busy=%b expected collide=%b busy=1", bus.collide, bus.busy, e.col); end
    @(negedge clk);
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL done_pulse_width: got %b expected 0", bus.done); end
    read_seg(0, 0, x, y, v);
    compared++; if (x !== 8'(e.hx) || y !== 7'(e.hy)) begin mismatched++; $display("[TB] FAIL right_head: got (%0d,%0d) expected (%0d,%0d)", x, y, e.hx, e.hy); end
    read_seg(0, e.len - 1, x, y, v);
    compared++; if (x !== 8'(e.tx) || y !== 7'(e.ty)) begin mismatched++; $display("[TB] FAIL right_tail: got (%0d,%0d) expected (%0d,%0d)", x, y, e.tx, e.ty); end
    compared++; if (bus.vac_x !== 8'(e.vx) || bus.vac_y !== 7'(e.vy) || bus.vac_valid !== e.vv) begin mismatched++; $display("[TB] FAIL right_vac: got (%0d,%0d,v=%b) expected (%0d,%0d,v=%b)", bus.vac_x, bus.vac_y, bus.vac_valid, e.vx, e.vy, e.vv); end
  endtask

  task automatic test_reverse_and_busy();
    exp_t e; int cyc; bit seen; logic [7:0] x; logic [6:0] y; logic v;
    do_reset();
    model_step(0, 0, 16);
    drive_step(0, 2'b00, 1'b0, 1'b0, 20, cyc, seen);
    e = sb.pop_front();
    model_step(3, 0, 16);
    drive_step(0, 2'b11, 1'b0, 1'b1, 20, cyc, seen);
    e = sb.pop_front();
    compared++; if (!seen || cyc != e.lat) begin mismatched++; $display("[TB] FAIL reverse_latency: got %0d (seen=%0b) expected %0d", cyc, seen, e.lat); end
    repeat (3) @(negedge clk);
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_step_queued: got busy=%b expected 0", bus.busy); end
    read_seg(0, 0, x, y, v);
    compared++; if (x !== 8'(e.hx) || y !== 7'(e.hy)) begin mismatched++; $display("[TB] FAIL reverse_head: got (%0d,%0d) expected (%0d,%0d)", x, y, e.hx, e.hy); end
  endtask

  task automatic test_grow_collide();
    exp_t e; int cyc; bit seen; logic [7:0] x; logic [6:0] y; logic v;
    int dirs [3] = '{1, 3, 2};
    bit grows [3] = '{1'b1, 1'b0, 1'b0};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      model_step(dirs[s], grows[s], 16);
      drive_step(0, 2'(dirs[s]), grows[s], 1'b0, 20, cyc, seen);
      e = sb.pop_front();
      compared++; if (!seen || cyc != e.lat) begin mismatched++; $display("[TB] FAIL grow_s%0d_latency: got %0d (seen=%0b) expected %0d", s, cyc, seen, e.lat); end
      compared++; if (bus.collide !== e.col || bus.dead !== (e.col | e.wal) || bus.wall !== e.wal) begin mismatched++; $display("[TB] FAIL grow_s%0d_flags: got c/w/d=%b%b%b expected %b%b%b", s, bus.collide, bus.wall, bus.dead, e.col, e.wal, e.col | e.wal); end
      compared++; if (bus.length !== 5'(e.len) || bus.vac_valid !== e.vv) begin mismatched++; $display("[TB] FAIL grow_s%0d_len: got len=%0d vv=%b expected len=%0d vv=%b", s, bus.length, bus.vac_valid, e.len, e.vv); end
      read_seg(0, 0, x, y, v);
      compared++; if (x !== 8'(e.hx) || y !== 7'(e.hy)) begin mismatched++; $display("[TB] FAIL grow_s%0d_head: got (%0d,%0d) expected (%0d,%0d)", s, x, y, e.hx, e.hy); end
    end
    // dead: a further step must be ignored
    drive_step(0, 2'b00, 1'b0, 1'b0, 10, cyc, seen);
    compared++; if (seen || bus.dead !== 1'b1 || bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL dead_ignores_step: got done=%b dead=%b busy=%b expected 0 1 0", seen, bus.dead, bus.busy); end
    read_seg(0, 0, x, y, v);
    compared++; if (x !== 8'(e.hx) || y !== 7'(e.hy)) begin mismatched++; $display("[TB] FAIL dead_head: got (%0d,%0d) expected (%0d,%0d)", x, y, e.hx, e.hy); end
  endtask

  task automatic test_wall();
    exp_t e; int cyc; bit seen; logic [7:0] x; logic [6:0] y; logic v;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      model_step(0, 0, 16);
      drive_step(0, 2'b00, 1'b0, 1'b0, 20, cyc, seen);
      e = sb.pop_front();
      compared++; if (!seen || cyc != e.lat) begin mismatched++; $display("[TB] FAIL wall_s%0d_latency: got %0d (seen=%0b) expected %0d", s, cyc, seen, e.lat); end
      compared++; if (bus.wall !== e.wal || bus.dead !== (e.col | e.wal)) begin mismatched++; $display("[TB] FAIL wall_s%0d_flags: got wall=%b dead=%b expected wall=%b dead=%b", s, bus.wall, bus.dead, e.wal, e.col | e.wal); end
      read_seg(0, 0, x, y, v);
      compared++; if (x !== 8'(e.hx) || y !== 7'(e.hy)) begin mismatched++; $display("[TB] FAIL wall_s%0d_head: got (%0d,%0d) expected (%0d,%0d)", s, x, y, e.hx, e.hy); end
    end
  endtask

  task automatic test_full_grow();
    exp_t e; int cyc; bit seen;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      model_step(0, 1, 5);
      drive_step(1, 2'b00, 1'b1, 1'b0, 20, cyc, seen);
      e = sb.pop_front();
      compared++; if (!seen || cyc != e.lat) begin mismatched++; $display("[TB] FAIL full_s%0d_latency: got %0d (seen=%0b) expected %0d", s, cyc, seen, e.lat); end
      compared++; if (bus5.length !== 3'(e.len) || bus5.full !== (e.len == 5)) begin mismatched++; $display("[TB] FAIL full_s%0d_len: got len=%0d full=%b expected len=%0d full=%b", s, bus5.length, bus5.full, e.len, e.len == 5); end
      compared++; if (bus5.vac_valid !== e.vv || (e.vv && (bus5.vac_x !== 8'(e.vx) || bus5.vac_y !== 7'(e.vy)))) begin mismatched++; $display("[TB] FAIL full_s%0d_vac: got (%0d,%0d,v=%b) expected (%0d,%0d,v=%b)", s, bus5.vac_x, bus5.vac_y, bus5.vac_valid, e.vx, e.vy, e.vv); end
    end
  endtask

  // Test sequence
  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    bus.step = 1'b0;  bus.dir = 2'b00;  bus.grow = 1'b0;  bus.rd_idx = '0;
    bus5.step = 1'b0; bus5.dir = 2'b00; bus5.grow = 1'b0; bus5.rd_idx = '0;
    test_reset();
    test_move_right();
    test_reverse_and_busy();
    test_grow_collide();
    test_wall();
    test_full_grow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
